muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for the RV32 M-extension ops that the single-cycle ALU does not finish in one cycle.
//  Sits beside the ALU in EX.
//  Accepts one MUL*/DIV*/REM* op and runs a radix-2 shift-add / restoring-divide loop.
//  Drives hold_pipeline to stall the pipeline until the result is ready, then presents the result for one cycle.
// PARAMETERS
//  data_width  32  operand/result width; iteration count = data_width
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           asynchronous, active-high reset
//  start         in   1           request; sampled only in IDLE
//  op            in   3           funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  operand_A     in   data_width  rs1 (multiplicand / dividend)
//  operand_B     in   data_width  rs2 (multiplier / divisor)
//  flush         in   1           abort any op in flight (branch/exception)
//  hold_pipeline out  1           stall request to pipeline
//  busy          out  1           state != IDLE
//  result_valid  out  1           one-cycle pulse, result valid
//  result        out  data_width  registered result; held until the next accepted op
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; count=0; result=0; result_valid=0; busy=0; hold_pipeline=0.
//   - All internal regs are cleared.
//  FSM states: IDLE, BUSY, DONE.
//   - IDLE: start && !flush -> operands and op are latched.
//     - Normal op -> BUSY, count=data_width.
//     - Special-case divide -> DONE directly (fast path).
//   - BUSY: one iteration per cycle, count--. At count==1 -> DONE.
//   - DONE: result_valid=1 for exactly one cycle -> IDLE.
//   - start is ignored in BUSY and DONE; no queueing.
//  Latency:
//   - Normal op: result_valid asserted data_width+1 cycles after the start edge (33 for default).
//   - Fast path: result_valid asserted 1 cycle after the start edge.
//  hold_pipeline (combinational):
//   - Asserted when (IDLE && start && !flush) || BUSY.
//   - Low in DONE, so the pipeline advances on the same edge it captures result.
//  Sign handling:
//   - Signed operands (MUL/MULH, A of MULHSU, DIV/REM) are converted to magnitudes at start.
//   - Result sign is fixed in the BUSY->DONE transition.
//   - MUL uses a 2*data_width-bit product: MUL returns the low half; MULH/MULHSU/MULHU return the high half.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//  Special cases (fast path, no BUSY):
//   - Divisor==0: DIV/DIVU -> all ones; REM/REMU -> operand_A.
//   - Signed overflow, A=-2^(w-1) with B=-1: DIV -> -2^(w-1); REM -> 0.
//  Flush:
//   - In any state -> IDLE on the next edge.
//   - result_valid is not pulsed and result is unchanged.
//   - hold_pipeline drops combinationally while flush=1.
//   - flush && start in IDLE: flush wins, op not accepted.
//  Reset mid-operation: aborts immediately, no result_valid.
//  Counter: $clog2(data_width)+1 bits; never wraps (reloaded only in IDLE).
// TESTING
//  - MUL A=7, B=-3 -> result=0xFFFFFFEB (-21); result_valid at cycle 33; hold_pipeline high cycles 0..32.
//  - MULH A=B=0x80000000 -> 0x40000000. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU A=-1, B=2 -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; each result_valid 1 cycle after start.
//  - flush at cycle 10 of a DIV -> IDLE next cycle, no result_valid, result unchanged.
//    A new start 1 cycle later completes normally.
//  - rst asserted mid-BUSY (async, between edges) -> all outputs 0 immediately.
//    start pulses during BUSY/DONE are ignored (result matches the first op only).

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32 M-extension unit: radix-2 shift-add multiply and restoring divide.
// Stalls the pipeline while iterating, then presents the result for one cycle.
module muldiv_sequencer #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    input  logic                  flush,
    output logic                  hold_pipeline,
    output logic                  busy,
    output logic                  result_valid,
    output logic [data_width-1:0] result
);
    localparam int cnt_w = $clog2(data_width) + 1;
    localparam int dw2   = 2 * data_width;
    localparam logic [data_width-1:0] min_val = {1'b1, {(data_width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_reg, state_next;
    logic [cnt_w-1:0]      count_reg, count_next;
    logic [2:0]            op_reg;
    logic [data_width-1:0] addend_reg;
    logic [dw2-1:0]        work_reg;
    logic                  neg_q_reg, neg_r_reg;
    logic [data_width-1:0] result_reg;
    logic                  accept, finish;

    logic                  is_div, a_signed, b_signed, a_neg, b_neg;
    logic [data_width-1:0] a_mag, b_mag;
    logic                  div_zero, div_ovf, special;
    logic [data_width-1:0] special_value;

    always_comb begin
        is_div   = op[2];
        a_signed = is_div ? !op[0] : (op[1:0] != 2'b11);
        b_signed = is_div ? !op[0] : !op[1];
        a_neg    = a_signed && operand_A[data_width-1];
        b_neg    = b_signed && operand_B[data_width-1];
        a_mag    = a_neg ? -operand_A : operand_A;
        b_mag    = b_neg ? -operand_B : operand_B;
        div_zero = is_div && (operand_B == '0);
        div_ovf  = is_div && !op[0] && (operand_A == min_val) && (operand_B == '1);
        special  = div_zero || div_ovf;
        // op[1] separates quotient ops (DIV/DIVU) from remainder ops (REM/REMU)
        if (!op[1]) begin
            special_value = div_zero ? '1 : min_val;
        end else begin
            special_value = div_zero ? operand_A : '0;
        end
    end

    logic [data_width:0]   mul_sum, div_shift, div_diff;
    logic                  div_ge;
    logic [dw2-1:0]        work_step, prod_signed;
    logic [data_width-1:0] quo, rem, final_value;

    // work_reg holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, work_reg[dw2-1:data_width]} + (work_reg[0] ? {1'b0, addend_reg} : '0);
        div_shift = work_reg[dw2-1:data_width-1];
        div_diff  = div_shift - {1'b0, addend_reg};
        div_ge    = !div_diff[data_width];
        if (op_reg[2]) begin
            work_step = {(div_ge ? div_diff[data_width-1:0] : div_shift[data_width-1:0]),
                         work_reg[data_width-2:0], div_ge};
        end else begin
            work_step = {mul_sum, work_reg[data_width-1:1]};
        end
        prod_signed = neg_q_reg ? -work_step : work_step;
        quo = work_step[data_width-1:0];
        rem = work_step[dw2-1:data_width];
        if (!op_reg[2]) begin
            final_value = (op_reg[1:0] == 2'b00) ? prod_signed[data_width-1:0]
                                                 : prod_signed[dw2-1:data_width];
        end else if (!op_reg[1]) begin
            final_value = neg_q_reg ? -quo : quo;
        end else begin
            final_value = neg_r_reg ? -rem : rem;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    accept = 1'b1;
                    if (special) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        count_next = cnt_w'(data_width);
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - 1'b1;
                    if (count_reg == cnt_w'(1)) begin
                        state_next = DONE;
                        finish     = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            addend_reg <= '0;
            work_reg   <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                op_reg     <= op;
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                addend_reg <= is_div ? b_mag : a_mag;
                work_reg   <= {{data_width{1'b0}}, (is_div ? a_mag : b_mag)};
                if (special) begin
                    result_reg <= special_value;
                end
            end else if (state_reg == BUSY && !flush) begin
                work_reg <= work_step;
                if (finish) begin
                    result_reg <= final_value;
                end
            end
        end
    end

    assign busy          = (state_reg != IDLE);
    assign result_valid  = (state_reg == DONE);
    assign hold_pipeline = (((state_reg == IDLE) && start) || (state_reg == BUSY)) && !flush;
    assign result        = result_reg;
endmodule
